// File: rtl/wbs_pit_defs.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : wbs_pit_defs
// Brief   : Register map, CSR bit positions and CSR packing for wbs_pit.
// Revision: 1.0 - initial release
// ============================================================================
package wbs_pit_defs;

    typedef enum logic [1:0] {
        ADR_CSR    = 2'd0,
        ADR_RELOAD = 2'd1,
        ADR_COUNT  = 2'd2,
        ADR_RSVD   = 2'd3
    } pit_adr_e;

    localparam int c_CSR_RUN  = 0;
    localparam int c_CSR_AUTO = 1;
    localparam int c_CSR_IE   = 6;
    localparam int c_CSR_DONE = 7;
    localparam int c_CSR_OVF  = 15;

    function automatic logic [15:0] pack_csr(
        input logic run,
        input logic auto_rl,
        input logic ie,
        input logic done,
        input logic ovf
    );
        logic [15:0] v;
        v              = 16'h0000;
        v[c_CSR_RUN]   = run;
        v[c_CSR_AUTO]  = auto_rl;
        v[c_CSR_IE]    = ie;
        v[c_CSR_DONE]  = done;
        v[c_CSR_OVF]   = ovf;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wbs_pit_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : wbs_pit_counter
// Brief   : RELOAD and COUNT registers with decrement and expiry detection.
// Revision: 1.0 - initial release
// ============================================================================
module wbs_pit_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_init,
    input  logic        i_run,
    input  logic        i_start,
    input  logic        i_tick_en,
    input  logic        i_auto,
    input  logic        i_reload_we,
    input  logic [15:0] i_reload_data,
    output logic [15:0] o_reload,
    output logic [15:0] o_count,
    output logic        o_expire
);

    logic [15:0] r_reload;
    logic [15:0] r_count;

    assign o_expire = i_tick_en & (r_count == 16'd1);
    assign o_reload = r_reload;
    assign o_count  = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reload <= 16'h0000;
            r_count  <= 16'h0000;
        end else if (i_init) begin
            r_reload <= 16'h0000;
            r_count  <= 16'h0000;
        end else begin
            if (i_reload_we) begin
                r_reload <= i_reload_data;
            end
            // start, stopped-reload and tick are mutually exclusive through i_run
            if (i_start) begin
                r_count <= r_reload;
            end else if (i_reload_we && !i_run) begin
                r_count <= i_reload_data;
            end else if (i_tick_en) begin
                if (o_expire) begin
                    r_count <= i_auto ? r_reload : 16'h0000;
                end else begin
                    r_count <= r_count - 16'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wbs_pit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : wbs_pit
// Brief   : Wishbone programmable interval timer with vectored interrupt.
// Revision: 1.0 - initial release
// ============================================================================
module wbs_pit
    import wbs_pit_defs::*;
#(
    parameter logic [15:0] VECTOR   = 16'o000100,
    parameter logic        RUN_INIT = 1'b0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        init_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    output logic        wb_ack_o,
    input  logic        tick_i,
    output logic        irq_o,
    input  logic        istb_i,
    output logic [15:0] ivec_o,
    output logic        iack_o
);

    logic        r_ack;
    logic        r_run;
    logic        r_auto;
    logic        r_ie;
    logic        r_done;
    logic        r_ovf;
    logic        r_pend;
    logic        r_iack;
    logic [15:0] r_ivec;

    logic        w_wr;
    logic        w_csr_lo;
    logic        w_csr_hi;
    logic        w_reload_wr;
    logic        w_start;
    logic        w_run_wr;
    logic        w_tick_en;
    logic        w_expire;
    logic [15:0] w_reload;
    logic [15:0] w_count;
    logic [15:0] w_reload_data;

    logic        w_run_nx;
    logic        w_auto_nx;
    logic        w_ie_nx;
    logic        w_done_nx;
    logic        w_ovf_nx;
    logic        w_pend_nx;
    logic        w_iack_nx;

    assign w_wr        = wb_cyc_i & wb_stb_i & wb_we_i & ~r_ack;
    assign w_csr_lo    = w_wr & (wb_adr_i == ADR_CSR) & wb_sel_i[0];
    assign w_csr_hi    = w_wr & (wb_adr_i == ADR_CSR) & wb_sel_i[1];
    assign w_reload_wr = w_wr & (wb_adr_i == ADR_RELOAD);

    assign w_reload_data = {wb_sel_i[1] ? wb_dat_i[15:8] : w_reload[15:8],
                            wb_sel_i[0] ? wb_dat_i[7:0]  : w_reload[7:0]};

    assign w_run_wr  = w_csr_lo ? wb_dat_i[c_CSR_RUN] : r_run;
    assign w_start   = w_csr_lo & ~r_run & wb_dat_i[c_CSR_RUN];
    // a write clearing RUN swallows a coincident tick
    assign w_tick_en = tick_i & r_run & w_run_wr;

    wbs_pit_counter u_counter (
        .clk           (wb_clk_i),
        .rst_n         (wb_rst_n),
        .i_init        (init_i),
        .i_run         (r_run),
        .i_start       (w_start),
        .i_tick_en     (w_tick_en),
        .i_auto        (r_auto),
        .i_reload_we   (w_reload_wr),
        .i_reload_data (w_reload_data),
        .o_reload      (w_reload),
        .o_count       (w_count),
        .o_expire      (w_expire)
    );

    always_comb begin
        w_run_nx  = w_run_wr;
        w_auto_nx = w_csr_lo ? wb_dat_i[c_CSR_AUTO] : r_auto;
        w_ie_nx   = w_csr_lo ? wb_dat_i[c_CSR_IE]   : r_ie;
        w_done_nx = r_done & ~(w_csr_lo & ~wb_dat_i[c_CSR_DONE]);
        w_ovf_nx  = r_ovf  & ~(w_csr_hi & ~wb_dat_i[c_CSR_OVF]);
        // hardware set of DONE/OVF overrides the software clear above
        if (w_expire) begin
            w_done_nx = 1'b1;
            if (r_done) begin
                w_ovf_nx = 1'b1;
            end
            if (!r_auto) begin
                w_run_nx = 1'b0;
            end
        end

        w_iack_nx = istb_i & (r_pend | r_iack);
        w_pend_nx = r_pend;
        if (istb_i && r_pend && !r_iack) begin
            w_pend_nx = 1'b0;
        end
        if (!w_done_nx || !w_ie_nx) begin
            w_pend_nx = 1'b0;
        end else if ((!r_done && w_done_nx) || (!r_ie && w_ie_nx)) begin
            w_pend_nx = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_ack  <= 1'b0;
            r_run  <= RUN_INIT;
            r_auto <= 1'b0;
            r_ie   <= 1'b0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            r_pend <= 1'b0;
            r_iack <= 1'b0;
            r_ivec <= 16'h0000;
        end else if (init_i) begin
            r_ack  <= 1'b0;
            r_run  <= RUN_INIT;
            r_auto <= 1'b0;
            r_ie   <= 1'b0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            r_pend <= 1'b0;
            r_iack <= 1'b0;
            r_ivec <= 16'h0000;
        end else begin
            r_ack  <= wb_cyc_i & wb_stb_i;
            r_run  <= w_run_nx;
            r_auto <= w_auto_nx;
            r_ie   <= w_ie_nx;
            r_done <= w_done_nx;
            r_ovf  <= w_ovf_nx;
            r_pend <= w_pend_nx;
            r_iack <= w_iack_nx;
            r_ivec <= w_iack_nx ? VECTOR : 16'h0000;
        end
    end

    always_comb begin
        wb_dat_o = 16'h0000;
        case (wb_adr_i)
            ADR_CSR:    wb_dat_o = pack_csr(r_run, r_auto, r_ie, r_done, r_ovf);
            ADR_RELOAD: wb_dat_o = w_reload;
            ADR_COUNT:  wb_dat_o = w_count;
            default:    wb_dat_o = 16'h0000;
        endcase
    end

    assign wb_ack_o = r_ack;
    assign irq_o    = r_pend;
    assign iack_o   = r_iack;
    assign ivec_o   = r_ivec;

endmodule
`default_nettype wire

// File: tb/tb_wbs_pit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_wbs_pit
// Brief   : Directed self-checking bench for wbs_pit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wbs_pit;
    import wbs_pit_defs::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init = 1'b0;
    logic [1:0]  adr = 2'd0;
    logic [15:0] dat_w = 16'h0000;
    logic [15:0] dat_r;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  sel = 2'b11;
    logic        ack;
    logic        tick = 1'b0;
    logic        irq;
    logic        istb = 1'b0;
    logic [15:0] ivec;
    logic        iack;

    int checks = 0;
    int errors = 0;
    logic [15:0] v;

    always #5 clk = ~clk;

    wbs_pit u_dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .init_i   (init),
        .wb_adr_i (adr),
        .wb_dat_i (dat_w),
        .wb_dat_o (dat_r),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_sel_i (sel),
        .wb_ack_o (ack),
        .tick_i   (tick),
        .irq_o    (irq),
        .istb_i   (istb),
        .ivec_o   (ivec),
        .iack_o   (iack)
    );

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d, input logic [1:0] s);
        @(negedge clk);
        adr = a; dat_w = d; sel = s; cyc = 1'b1; stb = 1'b1; we = 1'b1;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        @(negedge clk);
        adr = a;
        #1 d = dat_r;
    endtask

    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic test_reset();
        bus_read(ADR_CSR, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_csr got %h want %h", v, 16'h0000); end
        bus_read(ADR_RELOAD, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_reload got %h want %h", v, 16'h0000); end
        bus_read(ADR_COUNT, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_count got %h want %h", v, 16'h0000); end
        checks++; if ({ack, irq, iack, ivec} !== 19'h0) begin errors++; $display("FAIL reset_outs got %b%b%b %h want 000 0000", ack, irq, iack, ivec); end
    endtask

    task automatic test_ack();
        @(negedge clk);
        adr = ADR_RSVD; dat_w = 16'hFFFF; sel = 2'b11; cyc = 1'b1; stb = 1'b1; we = 1'b1;
        #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ack_pre got %b want 0", ack); end
        @(posedge clk); #1;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ack_rise got %b want 1", ack); end
        @(posedge clk); #1;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ack_hold got %b want 1", ack); end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ack_fall got %b want 0", ack); end
        bus_read(ADR_RSVD, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rsvd_read got %h want 0000", v); end
    endtask

    task automatic test_periodic();
        bus_write(ADR_RELOAD, 16'd3, 2'b11);
        bus_read(ADR_COUNT, v);
        checks++; if (v !== 16'd3) begin errors++; $display("FAIL stopped_reload_count got %h want 0003", v); end
        bus_write(ADR_CSR, 16'h0043, 2'b11);
        do_tick();
        bus_read(ADR_COUNT, v);
        checks++; if (v !== 16'd2) begin errors++; $display("FAIL per_tick1 got %h want 0002", v); end
        do_tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL per_irq_early got %b want 0", irq); end
        do_tick();
        bus_read(ADR_COUNT, v);
        checks++; if (v !== 16'd3) begin errors++; $display("FAIL per_reload got %h want 0003", v); end
        bus_read(ADR_CSR, v);
        checks++; if (v !== 16'h00C3) begin errors++; $display("FAIL per_csr got %h want 00c3", v); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL per_irq got %b want 1", irq); end
    endtask

    task automatic test_vector();
        @(negedge clk);
        istb = 1'b1;
        #1;
        checks++; if (iack !== 1'b0) begin errors++; $display("FAIL iack_c1 got %b want 0", iack); end
        @(posedge clk); #1;
        checks++; if (iack !== 1'b1 || ivec !== 16'h0040) begin errors++; $display("FAIL iack_c2 got %b %h want 1 0040", iack, ivec); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_ack got %b want 0", irq); end
        @(posedge clk); #1;
        checks++; if (iack !== 1'b1 || ivec !== 16'h0040) begin errors++; $display("FAIL iack_c3 got %b %h want 1 0040", iack, ivec); end
        @(negedge clk);
        istb = 1'b0;
        @(posedge clk); #1;
        checks++; if (iack !== 1'b0 || ivec !== 16'h0000) begin errors++; $display("FAIL iack_end got %b %h want 0 0000", iack, ivec); end
        @(negedge clk);
        istb = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (iack !== 1'b0) begin errors++; $display("FAIL iack_nopend got %b want 0", iack); end
        @(negedge clk);
        istb = 1'b0;
        bus_write(ADR_CSR, 16'h0000, 2'b11);
    endtask

    task automatic test_oneshot();
        bus_write(ADR_RELOAD, 16'd2, 2'b11);
        bus_write(ADR_CSR, 16'h0001, 2'b11);
        do_tick();
        do_tick();
        bus_read(ADR_CSR, v);
        checks++; if (v !== 16'h0080) begin errors++; $display("FAIL os_csr got %h want 0080", v); end
        bus_read(ADR_COUNT, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL os_count got %h want 0000", v); end
        do_tick();
        do_tick();
        bus_read(ADR_COUNT, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL os_stuck got %h want 0000", v); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL os_irq got %b want 0", irq); end
    endtask

    task automatic test_overflow();
        // DONE is 1 from the one-shot; writing 1 to it must not clear it
        bus_write(ADR_CSR, 16'h0083, 2'b11);
        bus_read(ADR_COUNT, v);
        checks++; if (v !== 16'd2) begin errors++; $display("FAIL ovf_start got %h want 0002", v); end
        do_tick();
        @(negedge clk);
        adr = ADR_CSR; dat_w = 16'h0003; sel = 2'b11; cyc = 1'b1; stb = 1'b1; we = 1'b1; tick = 1'b1;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; tick = 1'b0;
        bus_read(ADR_CSR, v);
        checks++; if (v !== 16'h8083) begin errors++; $display("FAIL ovf_race_csr got %h want 8083", v); end
        bus_read(ADR_COUNT, v);
        checks++; if (v !== 16'd2) begin errors++; $display("FAIL ovf_race_count got %h want 0002", v); end
        @(negedge clk);
        adr = ADR_CSR; dat_w = 16'h0082; sel = 2'b01; cyc = 1'b1; stb = 1'b1; we = 1'b1; tick = 1'b1;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; tick = 1'b0;
        bus_read(ADR_CSR, v);
        checks++; if (v !== 16'h8082) begin errors++; $display("FAIL stop_race_csr got %h want 8082", v); end
        bus_read(ADR_COUNT, v);
        checks++; if (v !== 16'd2) begin errors++; $display("FAIL stop_race_count got %h want 0002", v); end
        bus_write(ADR_CSR, 16'h0000, 2'b11);
        bus_read(ADR_CSR, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL flag_clear got %h want 0000", v); end
    endtask

    task automatic test_period_65536();
        bus_write(ADR_RELOAD, 16'd0, 2'b11);
        bus_write(ADR_CSR, 16'h0003, 2'b11);
        @(negedge clk);
        tick = 1'b1;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        tick = 1'b0;
        bus_read(ADR_COUNT, v);
        checks++; if (v !== 16'd1) begin errors++; $display("FAIL p64k_count got %h want 0001", v); end
        bus_read(ADR_CSR, v);
        checks++; if (v !== 16'h0003) begin errors++; $display("FAIL p64k_early got %h want 0003", v); end
        do_tick();
        bus_read(ADR_CSR, v);
        checks++; if (v !== 16'h0083) begin errors++; $display("FAIL p64k_done got %h want 0083", v); end
        bus_write(ADR_CSR, 16'h0000, 2'b11);
    endtask

    task automatic test_bytes();
        bus_write(ADR_RELOAD, 16'hABCD, 2'b01);
        bus_read(ADR_RELOAD, v);
        checks++; if (v !== 16'h00CD) begin errors++; $display("FAIL sel_lo got %h want 00cd", v); end
        bus_write(ADR_RELOAD, 16'h12FF, 2'b10);
        bus_read(ADR_COUNT, v);
        checks++; if (v !== 16'h12CD) begin errors++; $display("FAIL sel_hi_count got %h want 12cd", v); end
        bus_write(ADR_COUNT, 16'h5555, 2'b11);
        bus_read(ADR_COUNT, v);
        checks++; if (v !== 16'h12CD) begin errors++; $display("FAIL count_ro got %h want 12cd", v); end
        bus_write(ADR_CSR, 16'h0001, 2'b11);
        bus_write(ADR_RELOAD, 16'h0010, 2'b11);
        do_tick();
        bus_read(ADR_COUNT, v);
        checks++; if (v !== 16'h12CC) begin errors++; $display("FAIL run_reload_count got %h want 12cc", v); end
        bus_read(ADR_RELOAD, v);
        checks++; if (v !== 16'h0010) begin errors++; $display("FAIL run_reload got %h want 0010", v); end
    endtask

    task automatic test_init();
        @(negedge clk);
        init = 1'b1; tick = 1'b1;
        adr = ADR_CSR; dat_w = 16'h00FF; sel = 2'b11; cyc = 1'b1; stb = 1'b1; we = 1'b1;
        @(posedge clk); #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL init_ack got %b want 0", ack); end
        @(negedge clk);
        init = 1'b0; tick = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        bus_read(ADR_CSR, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL init_csr got %h want 0000", v); end
        bus_read(ADR_RELOAD, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL init_reload got %h want 0000", v); end
        bus_read(ADR_COUNT, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL init_count got %h want 0000", v); end
    endtask

    task automatic test_async_reset();
        bus_write(ADR_CSR, 16'h0001, 2'b11);
        @(negedge clk);
        adr = ADR_RELOAD; dat_w = 16'h1234; sel = 2'b11; cyc = 1'b1; stb = 1'b1; we = 1'b1;
        @(posedge clk); #1;
        checks++; if (ack !== 1'b1 || dat_r !== 16'h1234) begin errors++; $display("FAIL ar_pre got %b %h want 1 1234", ack, dat_r); end
        rst_n = 1'b0;
        #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ar_ack got %b want 0", ack); end
        checks++; if (dat_r !== 16'h0000) begin errors++; $display("FAIL ar_reload got %h want 0000", dat_r); end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = ADR_CSR;
        #1;
        checks++; if (dat_r !== 16'h0000) begin errors++; $display("FAIL ar_csr got %h want 0000", dat_r); end
        adr = ADR_COUNT;
        #1;
        checks++; if (dat_r !== 16'h0000) begin errors++; $display("FAIL ar_count got %h want 0000", dat_r); end
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_ack();
        test_periodic();
        test_vector();
        test_oneshot();
        test_overflow();
        test_period_65536();
        test_bytes();
        test_init();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
